// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pipe_pkg - shared types for the 5-stage pipeline hazard control  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_ERR      = 2'b10
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_sel_unit - bypass source select for one EX operand (MEM > WB)     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fwd_sel_unit
  import mips_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] rd_mem,
  input  logic       reg_wr_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_wr_wb,
  output fwd_sel_t   sel
);

  // $0 is hardwired, so a write to it never produces a bypass
  always_comb begin
    sel = FWD_RF;
    if (reg_wr_mem && (rd_mem != 5'd0) && (rd_mem == src))
      sel = FWD_MEM;
    else if (reg_wr_wb && (rd_wb != 5'd0) && (rd_wb == src))
      sel = FWD_WB;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl - stall/flush/forwarding control, stall-cycle count  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int DELAY_SLOT  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_iss,
  input  logic [4:0]       rt_iss,
  input  logic [4:0]       rs_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rd_ex,
  input  logic             reg_wr_ex,
  input  logic             is_load_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_wr_mem,
  input  logic [4:0]       rd_wb,
  input  logic             reg_wr_wb,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  output logic             stall_fetch,
  output logic             stall_iss,
  output logic             bubble_ex,
  output logic             freeze_all,
  output logic             flush_fetch,
  output logic             flush_iss,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic            freeze;
  logic            mem_stall;
  logic            load_use;
  logic            lu_stall;
  fwd_sel_t        fwd_a;
  fwd_sel_t        fwd_b;

  fwd_sel_unit u_fwd_a (
    .src(rs_ex), .rd_mem(rd_mem), .reg_wr_mem(reg_wr_mem),
    .rd_wb(rd_wb), .reg_wr_wb(reg_wr_wb), .sel(fwd_a)
  );

  fwd_sel_unit u_fwd_b (
    .src(rt_ex), .rd_mem(rd_mem), .reg_wr_mem(reg_wr_mem),
    .rd_wb(rd_wb), .reg_wr_wb(reg_wr_wb), .sel(fwd_b)
  );

  assign mem_stall = dmem_req_mem & ~dmem_ack;

  always_comb begin
    freeze = 1'b0;
    case (state)
      HZ_RUN:      freeze = mem_stall;
      HZ_MEM_WAIT: freeze = ~dmem_ack;
      default:     freeze = 1'b1;
    endcase
  end

  assign load_use = (state == HZ_RUN) & is_load_ex & reg_wr_ex & (rd_ex != 5'd0) &
                    ((rd_ex == rs_iss) | (rd_ex == rt_iss));

  // Outputs are forced low while reset is held so an async reset takes effect mid-cycle
  assign freeze_all  = reset & freeze;
  assign flush_fetch = reset & ~freeze & branch_taken_ex;
  assign flush_iss   = flush_fetch & (DELAY_SLOT == 0);
  assign lu_stall    = reset & ~freeze & ~branch_taken_ex & load_use;
  assign stall_fetch = lu_stall;
  assign stall_iss   = lu_stall;
  assign bubble_ex   = lu_stall;
  assign fwd_a_sel   = reset ? fwd_a : FWD_RF;
  assign fwd_b_sel   = reset ? fwd_b : FWD_RF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= HZ_RUN;
      wait_cnt        <= '0;
      stall_cnt       <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if ((lu_stall | freeze_all) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        HZ_RUN: begin
          if (mem_stall) begin
            wait_cnt <= WAIT_W'(1);
            state    <= HZ_MEM_WAIT;
          end
        end
        HZ_MEM_WAIT: begin
          if (dmem_ack) begin
            wait_cnt <= '0;
            state    <= HZ_RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            mem_timeout_err <= 1'b1;
            state           <= HZ_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HZ_ERR:  state <= HZ_ERR;
        default: state <= HZ_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl - directed vector bench for pipe_hazard_ctrl      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic reg_wr_ex, is_load_ex, reg_wr_mem, reg_wr_wb, branch_taken_ex, dmem_req_mem, dmem_ack;

  logic       sf [2], si [2], bx [2], fz [2], ff [2], fi [2], err [2];
  logic [1:0] fa [2], fb [2];
  logic [31:0] cnt_a;
  logic [2:0]  cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int exp_a = 0;
  int exp_b = 0;

  always #5 clk = ~clk;

  // a: delay slot kept, wide counter; b: no delay slot, 3-bit counter to reach saturation
  pipe_hazard_ctrl #(.DELAY_SLOT(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .rs_iss(rs_iss), .rt_iss(rt_iss), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .reg_wr_ex(reg_wr_ex), .is_load_ex(is_load_ex), .rd_mem(rd_mem),
    .reg_wr_mem(reg_wr_mem), .rd_wb(rd_wb), .reg_wr_wb(reg_wr_wb),
    .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .stall_fetch(sf[0]), .stall_iss(si[0]), .bubble_ex(bx[0]), .freeze_all(fz[0]),
    .flush_fetch(ff[0]), .flush_iss(fi[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .stall_cnt(cnt_a), .mem_timeout_err(err[0])
  );

  pipe_hazard_ctrl #(.DELAY_SLOT(0), .MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .rs_iss(rs_iss), .rt_iss(rt_iss), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .reg_wr_ex(reg_wr_ex), .is_load_ex(is_load_ex), .rd_mem(rd_mem),
    .reg_wr_mem(reg_wr_mem), .rd_wb(rd_wb), .reg_wr_wb(reg_wr_wb),
    .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .stall_fetch(sf[1]), .stall_iss(si[1]), .bubble_ex(bx[1]), .freeze_all(fz[1]),
    .flush_fetch(ff[1]), .flush_iss(fi[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .stall_cnt(cnt_b), .mem_timeout_err(err[1])
  );

  typedef struct {
    logic [4:0] rs_iss, rt_iss, rd_ex;
    logic       ld, wr_ex;
    logic [4:0] rs_ex, rt_ex, rd_mem;
    logic       wr_mem;
    logic [4:0] rd_wb;
    logic       wr_wb, br, e_stall, e_flush;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  function automatic vec_t mk(int a_rs_iss, int a_rt_iss, int a_rd_ex, int a_ld, int a_wr_ex,
                              int a_rs_ex, int a_rt_ex, int a_rd_mem, int a_wr_mem,
                              int a_rd_wb, int a_wr_wb, int a_br, int a_stall, int a_flush,
                              int a_fa, int a_fb);
    vec_t v;
    v.rs_iss = 5'(a_rs_iss); v.rt_iss = 5'(a_rt_iss); v.rd_ex = 5'(a_rd_ex);
    v.ld = 1'(a_ld); v.wr_ex = 1'(a_wr_ex); v.rs_ex = 5'(a_rs_ex); v.rt_ex = 5'(a_rt_ex);
    v.rd_mem = 5'(a_rd_mem); v.wr_mem = 1'(a_wr_mem); v.rd_wb = 5'(a_rd_wb);
    v.wr_wb = 1'(a_wr_wb); v.br = 1'(a_br); v.e_stall = 1'(a_stall); v.e_flush = 1'(a_flush);
    v.e_fa = 2'(a_fa); v.e_fb = 2'(a_fb);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_iss = 0; rt_iss = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    reg_wr_ex = 0; is_load_ex = 0; reg_wr_mem = 0; reg_wr_wb = 0;
    branch_taken_ex = 0; dmem_req_mem = 0; dmem_ack = 0;
  endtask

  task automatic set_load_use();
    rd_ex = 5'd2; is_load_ex = 1'b1; reg_wr_ex = 1'b1; rs_iss = 5'd2;
  endtask

  task automatic bump();
    exp_a++;
    if (exp_b != 7) exp_b++;
  endtask

  task automatic check_cnt(input string name);
    check({name, " cnt_a"}, cnt_a, 32'(exp_a));
    check({name, " cnt_b"}, 32'(cnt_b), 32'(exp_b));
  endtask

  vec_t vt [14];

  initial begin
    vt[0]  = mk( 0, 0,  0,0,0,  0, 0,  0,0,  0,0, 0, 0,0,0,0);
    vt[1]  = mk( 2, 7,  2,1,1,  0, 0,  0,0,  0,0, 0, 1,0,0,0);
    vt[2]  = mk( 9, 2,  2,1,1,  0, 0,  0,0,  0,0, 0, 1,0,0,0);
    vt[3]  = mk( 0, 0,  0,1,1,  0, 0,  0,0,  0,0, 0, 0,0,0,0);
    vt[4]  = mk( 2, 0,  2,1,0,  0, 0,  0,0,  0,0, 0, 0,0,0,0);
    vt[5]  = mk( 2, 0,  2,0,1,  0, 0,  0,0,  0,0, 0, 0,0,0,0);
    vt[6]  = mk( 0, 0,  0,0,0,  5, 0,  5,1,  5,1, 0, 0,0,1,0);
    vt[7]  = mk( 0, 0,  0,0,0,  1, 7,  7,0,  7,1, 0, 0,0,0,2);
    vt[8]  = mk( 0, 0,  0,0,0,  0, 0,  0,1,  0,1, 0, 0,0,0,0);
    vt[9]  = mk( 0, 0,  0,0,0,  4, 3,  3,1,  4,1, 0, 0,0,2,1);
    vt[10] = mk( 0, 0,  0,0,0,  0, 0,  0,0,  0,0, 1, 0,1,0,0);
    vt[11] = mk( 3, 0,  3,1,1,  0, 0,  0,0,  0,0, 1, 0,1,0,0);
    vt[12] = mk( 0, 0,  0,0,0,  6, 6,  6,1,  0,0, 1, 0,1,1,1);
    vt[13] = mk(31,31, 31,1,1, 31,31,  0,0, 31,1, 0, 1,0,2,2);

    idle();
    reset = 1'b0;
    #1;
    check("reset freeze", {31'd0, fz[0]}, 0);
    check("reset stall", {29'd0, sf[0], si[0], bx[0]}, 0);
    check("reset err", {31'd0, err[0]}, 0);
    check_cnt("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      rs_iss = vt[i].rs_iss; rt_iss = vt[i].rt_iss; rd_ex = vt[i].rd_ex;
      is_load_ex = vt[i].ld; reg_wr_ex = vt[i].wr_ex; rs_ex = vt[i].rs_ex; rt_ex = vt[i].rt_ex;
      rd_mem = vt[i].rd_mem; reg_wr_mem = vt[i].wr_mem; rd_wb = vt[i].rd_wb;
      reg_wr_wb = vt[i].wr_wb; branch_taken_ex = vt[i].br;
      #2;
      check($sformatf("v%0d stall", i), {29'd0, sf[0], si[0], bx[0]}, {29'd0, {3{vt[i].e_stall}}});
      check($sformatf("v%0d flush_fetch", i), {30'd0, ff[0], ff[1]}, {30'd0, {2{vt[i].e_flush}}});
      check($sformatf("v%0d flush_iss", i), {30'd0, fi[0], fi[1]}, {31'd0, vt[i].e_flush});
      check($sformatf("v%0d fwd", i), {28'd0, fa[0], fb[0]}, {28'd0, vt[i].e_fa, vt[i].e_fb});
      check($sformatf("v%0d freeze", i), {31'd0, fz[0]}, 0);
      tick();
      if (vt[i].e_stall) bump();
      check_cnt($sformatf("v%0d", i));
    end
    idle();

    // data-memory wait: three frozen cycles, branch and load-use masked, released on ack
    dmem_req_mem = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_load_use();
      branch_taken_ex = (k == 1);
      #2;
      check($sformatf("mw%0d freeze", k), {30'd0, fz[0], fz[1]}, 32'h3);
      check($sformatf("mw%0d masked", k), {30'd0, sf[0], ff[0]}, 0);
      tick();
      bump();
      check_cnt($sformatf("mw%0d", k));
    end
    idle();
    dmem_req_mem = 1'b1;
    dmem_ack = 1'b1;
    #2;
    check("mw ack freeze", {31'd0, fz[0]}, 0);
    tick();
    idle();
    set_load_use();
    #2;
    check("mw back in RUN", {31'd0, sf[0]}, 1);
    tick();
    bump();
    check_cnt("mw done");
    idle();

    // async reset in the middle of a memory wait
    dmem_req_mem = 1'b1;
    tick(); bump();
    tick(); bump();
    check_cnt("pre-reset");
    rs_ex = 5'd5; rd_mem = 5'd5; reg_wr_mem = 1'b1; branch_taken_ex = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp_a = 0; exp_b = 0;
    check("async rst freeze", {30'd0, fz[0], fz[1]}, 0);
    check("async rst flush", {31'd0, ff[0]}, 0);
    check("async rst fwd", {30'd0, fa[0]}, 0);
    check_cnt("async rst");
    @(negedge clk);
    idle();
    reset = 1'b1;
    tick();
    rs_ex = 5'd5; rd_mem = 5'd5; reg_wr_mem = 1'b1;
    #2;
    check("post rst freeze", {31'd0, fz[0]}, 0);
    check("post rst fwd", {30'd0, fa[0]}, 1);
    tick();
    idle();

    // timeout: four frozen cycles then sticky error, freeze held even after ack
    dmem_req_mem = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("to%0d freeze", k), {31'd0, fz[0]}, 1);
      tick();
      bump();
      check($sformatf("to%0d err", k), {30'd0, err[0], err[1]}, (k == 3) ? 32'h3 : 32'h0);
    end
    dmem_req_mem = 1'b0;
    dmem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("err%0d freeze", k), {30'd0, fz[0], fz[1]}, 32'h3);
      tick();
      bump();
    end
    check_cnt("err saturate");
    reset = 1'b0;
    #1;
    exp_a = 0; exp_b = 0;
    check("final rst err", {30'd0, err[0], err[1]}, 0);
    check("final rst freeze", {31'd0, fz[0]}, 0);
    check_cnt("final rst");
    @(negedge clk);
    idle();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
